// File: rtl/file_register_arbiter.sv
// Two-requester round-robin arbiter serialising single-word accesses to a shared 32x32 file register.
// Optional FILE_ARB_FIXED_PRIO_EN: requester 0 always wins simultaneous requests.
module file_register_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              op0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              op1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              rf_we,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wdata_oe,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_W = 2;
    // RWAIT lasts READ_LAT-1 cycles; the counter runs 0..READ_LAT-2.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("file_register_arbiter: READ_LAT must be in 1..4");
    end

    state_t            state_r;
    logic              op_r;
    logic [CNT_W-1:0]  wait_cnt_r;

    logic              any_req_s;
    logic              win_s;
    logic              sel_op_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Winner selection among the requesters present in this IDLE cycle.
    always_comb begin
        any_req_s = req0 | req1;
        win_s     = grant;
        if (req0 && req1) begin
`ifdef FILE_ARB_FIXED_PRIO_EN
            win_s = 1'b0;
`else
            win_s = ~grant;
`endif
        end else if (req0) begin
            win_s = 1'b0;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = grant;
        end
    end

    // Route the winning requester's transaction fields.
    always_comb begin
        sel_op_s    = op1;
        sel_addr_s  = addr1;
        sel_wdata_s = wdata1;
        if (win_s == 1'b0) begin
            sel_op_s    = op0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end else begin
            sel_op_s    = op1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end
    end

    // Transaction sequencer; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            op_r        <= 1'b0;
            wait_cnt_r  <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rf_we       <= 1'b0;
            rf_re       <= 1'b0;
            rf_wdata_oe <= 1'b0;
            rf_addr     <= '0;
            rf_wdata    <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
            grant       <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (any_req_s) begin
                        grant   <= win_s;
                        op_r    <= sel_op_s;
                        rf_addr <= sel_addr_s;
                        busy    <= 1'b1;
                        state_r <= ACCESS;
                        if (sel_op_s) begin
                            rf_we       <= 1'b1;
                            rf_wdata_oe <= 1'b1;
                            rf_wdata    <= sel_wdata_s;
                        end else begin
                            rf_re <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (op_r) begin
                        rf_we       <= 1'b0;
                        rf_wdata_oe <= 1'b0;
                        ack0        <= ~grant;
                        ack1        <= grant;
                        state_r     <= DONE;
                    end else if (READ_LAT > 1) begin
                        wait_cnt_r <= '0;
                        state_r    <= RWAIT;
                    end else begin
                        rf_re   <= 1'b0;
                        rdata   <= rf_rdata;
                        ack0    <= ~grant;
                        ack1    <= grant;
                        state_r <= DONE;
                    end
                end
                RWAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        rf_re   <= 1'b0;
                        rdata   <= rf_rdata;
                        ack0    <= ~grant;
                        ack1    <= grant;
                        state_r <= DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 2'd1;
                    end
                end
                DONE: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ack0        <= 1'b0;
                    ack1        <= 1'b0;
                    rf_we       <= 1'b0;
                    rf_re       <= 1'b0;
                    rf_wdata_oe <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    file_register_arbiter_checker u_checker (
        .clk         (clk),
        .rst         (rst),
        .ack0        (ack0),
        .ack1        (ack1),
        .rf_we       (rf_we),
        .rf_re       (rf_re),
        .rf_wdata_oe (rf_wdata_oe),
        .busy        (busy)
    );

endmodule

// Protocol invariants of the arbiter's outputs.
module file_register_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic ack0,
    input logic ack1,
    input logic rf_we,
    input logic rf_re,
    input logic rf_wdata_oe,
    input logic busy
);

    a_we_re_exclusive: assert property (@(posedge clk) disable iff (rst) !(rf_we && rf_re));
    a_oe_follows_we:   assert property (@(posedge clk) disable iff (rst) rf_wdata_oe == rf_we);
    a_ack_exclusive:   assert property (@(posedge clk) disable iff (rst) !(ack0 && ack1));
    a_ack0_single:     assert property (@(posedge clk) disable iff (rst) ack0 |=> !ack0);
    a_ack1_single:     assert property (@(posedge clk) disable iff (rst) ack1 |=> !ack1);
    a_ack_when_busy:   assert property (@(posedge clk) disable iff (rst) (ack0 || ack1) |-> busy);

endmodule

// File: tb/tb_file_register_arbiter.sv
// Randomised self-checking bench: two arbiter instances (READ_LAT 1 and 3) with latency-exact file register models.
module tb_file_register_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam logic [DW-1:0] POISON = 32'hDEAD_BEEF;
`ifdef FILE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic rst;
    logic          req0 [2];
    logic          op0 [2];
    logic [AW-1:0] addr0 [2];
    logic [DW-1:0] wdata0 [2];
    logic          req1 [2];
    logic          op1 [2];
    logic [AW-1:0] addr1 [2];
    logic [DW-1:0] wdata1 [2];
    logic          ack0 [2];
    logic          ack1 [2];
    logic [DW-1:0] rdata [2];
    logic          rf_we [2];
    logic          rf_re [2];
    logic [AW-1:0] rf_addr [2];
    logic [DW-1:0] rf_wdata [2];
    logic          rf_wdata_oe [2];
    logic [DW-1:0] rf_rdata [2];
    logic          busy [2];
    logic          grant [2];

    int checks = 0;
    int errors = 0;
    int last_owner = 1;
    logic [DW-1:0] ref_mem [32];
    bit            ref_known [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    file_register_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0[0]), .op0(op0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]), .ack0(ack0[0]),
        .req1(req1[0]), .op1(op1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]), .ack1(ack1[0]),
        .rdata(rdata[0]), .rf_we(rf_we[0]), .rf_re(rf_re[0]), .rf_addr(rf_addr[0]),
        .rf_wdata(rf_wdata[0]), .rf_wdata_oe(rf_wdata_oe[0]), .rf_rdata(rf_rdata[0]),
        .busy(busy[0]), .grant(grant[0])
    );

    file_register_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT1)) dut3 (
        .clk(clk), .rst(rst),
        .req0(req0[1]), .op0(op0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]), .ack0(ack0[1]),
        .req1(req1[1]), .op1(op1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]), .ack1(ack1[1]),
        .rdata(rdata[1]), .rf_we(rf_we[1]), .rf_re(rf_re[1]), .rf_addr(rf_addr[1]),
        .rf_wdata(rf_wdata[1]), .rf_wdata_oe(rf_wdata_oe[1]), .rf_rdata(rf_rdata[1]),
        .busy(busy[1]), .grant(grant[1])
    );

    // File register models: data is only valid in the READ_LAT-th cycle of rf_re.
    for (genvar g = 0; g < 2; g++) begin : g_rf
        localparam int GL = (g == 0) ? LAT0 : LAT1;
        logic [DW-1:0] mem [32];
        int re_cnt = 0;
        always @(posedge clk) begin
            if (rf_we[g] && rf_wdata_oe[g]) mem[rf_addr[g]] <= rf_wdata[g];
            re_cnt <= rf_re[g] ? re_cnt + 1 : 0;
        end
        assign rf_rdata[g] = (rf_re[g] && re_cnt == GL - 1) ? mem[rf_addr[g]] : POISON;
    end

    task automatic txn(input int d, input int r, input logic op, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd,
                       output int we_n, output int re_n, output int bad);
        lat = 0; rd = '0; we_n = 0; re_n = 0; bad = 0;
        if (r == 0) begin req0[d] = 1'b1; op0[d] = op; addr0[d] = a; wdata0[d] = wd; end
        else        begin req1[d] = 1'b1; op1[d] = op; addr1[d] = a; wdata1[d] = wd; end
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                // Changes after the sample edge must be ignored.
                if (r == 0) begin op0[d] = ~op; addr0[d] = ~a; wdata0[d] = ~wd; end
                else        begin op1[d] = ~op; addr1[d] = ~a; wdata1[d] = ~wd; end
            end
            if (rf_we[d]) begin we_n++; if (rf_addr[d] !== a || rf_wdata[d] !== wd || !op) bad++; end
            if (rf_re[d]) begin re_n++; if (rf_addr[d] !== a || op) bad++; end
            if (rf_we[d] !== rf_wdata_oe[d] || (rf_we[d] && rf_re[d]) || (ack0[d] && ack1[d])) bad++;
            if ((r == 0 && ack1[d]) || (r == 1 && ack0[d])) bad++;
            if ((r == 0 && ack0[d]) || (r == 1 && ack1[d])) begin
                lat = n; rd = rdata[d];
                break;
            end
        end
        if (r == 0) req0[d] = 1'b0; else req1[d] = 1'b0;
        @(posedge clk); #1;
        if (busy[d] !== 1'b0 || ack0[d] || ack1[d]) bad++;
        if (d == 0) begin
            last_owner = r;
            if (op) begin ref_mem[a] = wd; ref_known[a] = 1'b1; end
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({ack0[0], ack1[0], rf_we[0], rf_re[0], rf_wdata_oe[0], busy[0]} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000",
                {ack0[0], ack1[0], rf_we[0], rf_re[0], rf_wdata_oe[0], busy[0]});
        end
        checks++;
        if (rf_addr[0] !== 5'd0 || rf_wdata[0] !== 32'd0 || rdata[0] !== 32'd0) begin
            errors++; $display("FAIL reset_data got addr=%0d wdata=%h rdata=%h want 0", rf_addr[0], rf_wdata[0], rdata[0]);
        end
        checks++;
        if (grant[0] !== 1'b1) begin errors++; $display("FAIL reset_grant got %b want 1", grant[0]); end
    endtask

    task automatic test_write;
        int lat, we_n, re_n, bad; logic [DW-1:0] rd;
        txn(0, 0, 1'b1, 5'd5, 32'hFFFF000F, lat, rd, we_n, re_n, bad);
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency got %0d want 2", lat); end
        checks++; if (we_n !== 1 || re_n !== 0) begin errors++; $display("FAIL write_pulse got we=%0d re=%0d want 1 0", we_n, re_n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL write_protocol got %0d violations want 0", bad); end
    endtask

    task automatic test_read(input int d);
        int lat, we_n, re_n, bad, rl; logic [DW-1:0] rd;
        rl = (d == 0) ? LAT0 : LAT1;
        if (d != 0) txn(d, 0, 1'b1, 5'd5, 32'hFFFF000F, lat, rd, we_n, re_n, bad);
        txn(d, 0, 1'b0, 5'd5, 32'h0, lat, rd, we_n, re_n, bad);
        checks++; if (lat !== rl + 1) begin errors++; $display("FAIL read%0d_latency got %0d want %0d", rl, lat, rl + 1); end
        checks++; if (re_n !== rl || we_n !== 0) begin errors++; $display("FAIL read%0d_re_cycles got re=%0d we=%0d want %0d 0", rl, re_n, we_n, rl); end
        checks++; if (rd !== 32'hFFFF000F) begin errors++; $display("FAIL read%0d_data got %h want ffff000f", rl, rd); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL read%0d_protocol got %0d violations want 0", rl, bad); end
    endtask

    // Both requesters contend on DUT0; the model picks winners from the arbitration rules.
    task automatic test_contention(input int rounds, input bit rnd);
        logic pv [2]; logic pop [2]; logic [AW-1:0] pa [2]; logic [DW-1:0] pd [2];
        int served [2]; int w, act, n, exp_lat, bad;
        served[0] = 0; served[1] = 0;
        for (int i = 0; i < 2; i++) begin
            pv[i]  = 1'b1;
            pop[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pa[i]  = rnd ? AW'($urandom_range(0, 31)) : AW'(i + 1);
            pd[i]  = rnd ? DW'($urandom) : 32'hA5A5_0000 + DW'(i);
        end
        for (int k = 0; k < rounds; k++) begin
            if (!pv[0] && !pv[1]) pv[1] = 1'b1;
            req0[0] = pv[0]; op0[0] = pop[0]; addr0[0] = pa[0]; wdata0[0] = pd[0];
            req1[0] = pv[1]; op1[0] = pop[1]; addr1[0] = pa[1]; wdata1[0] = pd[1];
            if (pv[0] && pv[1]) w = FIXED ? 0 : 1 - last_owner;
            else                w = pv[0] ? 0 : 1;
            exp_lat = pop[w] ? 2 : LAT0 + 1;
            act = -1; n = 0; bad = 0;
            while (act < 0 && n < 16) begin
                @(posedge clk); #1; n++;
                if ((rf_we[0] && rf_re[0]) || rf_we[0] !== rf_wdata_oe[0] || (ack0[0] && ack1[0])) bad++;
                if (ack0[0]) act = 0; else if (ack1[0]) act = 1;
            end
            checks++; if (act !== w) begin errors++; $display("FAIL arb_winner round %0d got %0d want %0d", k, act, w); end
            checks++; if (n !== exp_lat) begin errors++; $display("FAIL arb_latency round %0d got %0d want %0d", k, n, exp_lat); end
            checks++; if (grant[0] !== 1'(w)) begin errors++; $display("FAIL arb_grant round %0d got %b want %0d", k, grant[0], w); end
            if (act >= 0) begin
                if (!pop[act] && ref_known[pa[act]]) begin
                    checks++;
                    if (rdata[0] !== ref_mem[pa[act]]) begin
                        errors++; $display("FAIL arb_rdata round %0d addr %0d got %h want %h", k, pa[act], rdata[0], ref_mem[pa[act]]);
                    end
                end
                if (pop[act]) begin ref_mem[pa[act]] = pd[act]; ref_known[pa[act]] = 1'b1; end
                last_owner = act;
                served[act]++;
                if (act == 0) req0[0] = 1'b0; else req1[0] = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (busy[0] !== 1'b0 || bad !== 0) begin errors++; $display("FAIL arb_protocol round %0d got busy=%b violations=%0d want 0 0", k, busy[0], bad); end
            if (act >= 0) begin
                pv[act]  = rnd ? ($urandom_range(0, 3) != 0) : (served[act] < rounds / 2);
                pop[act] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                pa[act]  = rnd ? AW'($urandom_range(0, 31)) : AW'(act + 1);
                pd[act]  = rnd ? DW'($urandom) : 32'hA5A5_0010 + DW'(k);
            end
        end
        req0[0] = 1'b0; req1[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read;
        int lat, we_n, re_n, bad, seen; logic [DW-1:0] rd;
        req0[0] = 1'b1; op0[0] = 1'b0; addr0[0] = 5'd7;
        @(posedge clk); #1;
        checks++; if (rf_re[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got rf_re=%b want 1", rf_re[0]); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({ack0[0], ack1[0], rf_we[0], rf_re[0], rf_wdata_oe[0], busy[0]} !== 6'b0 || rf_addr[0] !== 5'd0 ||
            rdata[0] !== 32'd0 || grant[0] !== 1'b1) begin
            errors++; $display("FAIL rst_mid_outputs got ctrl=%b addr=%0d rdata=%h grant=%b want 0 0 0 1",
                {ack0[0], ack1[0], rf_we[0], rf_re[0], rf_wdata_oe[0], busy[0]}, rf_addr[0], rdata[0], grant[0]);
        end
        req0[0] = 1'b0;
        @(negedge clk); rst = 1'b0;
        last_owner = 1;
        seen = 0;
        repeat (4) begin @(posedge clk); #1; if (ack0[0] || ack1[0] || busy[0]) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_ack got %0d active cycles want 0", seen); end
        txn(0, 0, 1'b0, 5'd5, 32'h0, lat, rd, we_n, re_n, bad);
        checks++;
        if (lat !== LAT0 + 1 || rd !== ref_mem[5] || bad !== 0) begin
            errors++; $display("FAIL rst_mid_recover got lat=%0d rdata=%h bad=%0d want %0d %h 0", lat, rd, bad, LAT0 + 1, ref_mem[5]);
        end
    endtask

    task automatic test_fill_readback;
        int lat, we_n, re_n, bad; logic [DW-1:0] rd;
        for (int a = 0; a < 32; a++) begin
            txn(0, 0, 1'b1, AW'(a), 32'h0000FFF0 + DW'(a), lat, rd, we_n, re_n, bad);
            checks++;
            if (lat !== 2 || we_n !== 1 || bad !== 0) begin
                errors++; $display("FAIL fill addr %0d got lat=%0d we=%0d bad=%0d want 2 1 0", a, lat, we_n, bad);
            end
        end
        for (int a = 0; a < 32; a++) begin
            txn(0, 1, 1'b0, AW'(a), 32'h0, lat, rd, we_n, re_n, bad);
            checks++;
            if (rd !== 32'h0000FFF0 + DW'(a) || lat !== LAT0 + 1 || re_n !== LAT0 || bad !== 0) begin
                errors++; $display("FAIL readback addr %0d got data=%h lat=%0d re=%0d bad=%0d want %h %0d %0d 0",
                    a, rd, lat, re_n, bad, 32'h0000FFF0 + DW'(a), LAT0 + 1, LAT0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req0[d] = 1'b0; op0[d] = 1'b0; addr0[d] = '0; wdata0[d] = '0;
            req1[d] = 1'b0; op1[d] = 1'b0; addr1[d] = '0; wdata1[d] = '0;
        end
        for (int i = 0; i < 32; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_write();
        test_read(0);
        test_read(1);
        test_contention(4, 1'b0);
        test_reset_mid_read();
        test_fill_readback();
        test_contention(60, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
